rx_word_deframer: RTL and testbench

Receive-side deframer directly downstream of the CDC stage. It consumes the already-synchronized serial bit stream `RXData` in the `RXClk` domain and detects start/stop framing. It reassembles LSB-first data bits into parallel words and presents each word through a one-entry valid/ready holding register, with framing, parity and overrun error reporting.

---
 rtl/rx_deframer_pkg.sv | 17 +
 rtl/rx_hold_reg.sv | 62 ++++++
 rtl/rx_word_deframer.sv | 129 ++++++++++++
 tb/tb_rx_word_deframer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_deframer_pkg.sv
// Shared types and line-level constants for the receive word deframer.
//   rx_state_t : deframer FSM states
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels
package rx_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register for deframed words.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   commit_i        : a good word is ready to be loaded this cycle
//   commit_word_i   : the word to load
//   ready_i         : consumer accepts word_o when valid_o & ready_i
//   word_o, valid_o : held word and its valid flag
//   overrun_o       : registered one-cycle pulse, commit dropped
//   overrun_set_o   : combinational overrun condition, for the error counter
module rx_hold_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] commit_word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             overrun_set_o
);

  logic [WIDTH-1:0] word_d, word_q;
  logic             valid_d, valid_q;
  logic             overrun_d, overrun_q;

  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A word leaving on this edge frees the slot for the incoming commit.
    if (commit_i) begin
      if (!valid_q || ready_i) begin
        word_d  = commit_word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_o        = word_q;
  assign valid_o       = valid_q;
  assign overrun_o     = overrun_q;
  assign overrun_set_o = overrun_d;

endmodule

// File: rtl/rx_word_deframer.sv
// Receive deframer: start/stop framing, LSB-first word assembly, optional
// even parity, one-entry output holding register and saturating error count.
//   RXClk, RXResetN       : clock, synchronous active-low reset
//   RXData                : synchronized serial bit, one per clock
//   WordOut, WordValid    : received word and valid flag
//   WordReady             : consumer handshake
//   FrameErr, ParityErr   : one-cycle error pulses
//   Overrun               : one-cycle pulse, good word dropped
//   ErrCount              : saturating count of all error pulses
module rx_word_deframer
  import rx_deframer_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned ERRW      = 8
) (
  input  logic             RXClk,
  input  logic             RXResetN,
  input  logic             RXData,
  output logic [WIDTH-1:0] WordOut,
  output logic             WordValid,
  input  logic             WordReady,
  output logic             FrameErr,
  output logic             ParityErr,
  output logic             Overrun,
  output logic [ERRW-1:0]  ErrCount
);

  localparam int unsigned CntW = $clog2(WIDTH);

  rx_state_t        state_d, state_q;
  logic [CntW-1:0]  bit_cnt_d, bit_cnt_q;
  logic [WIDTH-1:0] shift_d, shift_q;
  logic             par_err_d, par_err_q;
  logic             frame_err_d, frame_err_q;
  logic             parity_err_d, parity_err_q;
  logic [ERRW-1:0]  err_cnt_d, err_cnt_q;
  logic             commit;
  logic             overrun_set;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RXData == START_BIT) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        shift_d   = {RXData, shift_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(WIDTH - 1)) begin
          state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          bit_cnt_d = '0;
        end
      end
      PARITY: begin
        par_err_d = (^shift_q) ^ RXData;
        state_d   = STOP;
      end
      STOP: begin
        // A bad stop bit masks any parity error; the 1 is not a start bit.
        if (RXData != STOP_BIT) begin
          frame_err_d = 1'b1;
        end else if (par_err_q) begin
          parity_err_d = 1'b1;
        end else begin
          commit = 1'b1;
        end
        par_err_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((frame_err_d || parity_err_d || overrun_set) && (err_cnt_q != {ERRW{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge RXClk) begin
    if (!RXResetN) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  rx_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i         (RXClk),
    .rst_ni        (RXResetN),
    .commit_i      (commit),
    .commit_word_i (shift_q),
    .ready_i       (WordReady),
    .word_o        (WordOut),
    .valid_o       (WordValid),
    .overrun_o     (Overrun),
    .overrun_set_o (overrun_set)
  );

  assign FrameErr  = frame_err_q;
  assign ParityErr = parity_err_q;
  assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_rx_word_deframer.sv
// Bench for rx_word_deframer: one 32-bit no-parity instance and one 24-bit
// parity instance share the stimulus; only the selected one is checked.
module tb_rx_word_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx_data, ready;

  logic [31:0] word_a;
  logic        valid_a, ferr_a, perr_a, ovr_a;
  logic [7:0]  cnt_a;
  logic [23:0] word_b;
  logic        valid_b, ferr_b, perr_b, ovr_b;
  logic [7:0]  cnt_b;

  rx_word_deframer #(.WIDTH(32), .PARITY_EN(0), .ERRW(8)) u_dut_a (
    .RXClk(clk), .RXResetN(rst_n), .RXData(rx_data),
    .WordOut(word_a), .WordValid(valid_a), .WordReady(ready),
    .FrameErr(ferr_a), .ParityErr(perr_a), .Overrun(ovr_a), .ErrCount(cnt_a)
  );

  rx_word_deframer #(.WIDTH(24), .PARITY_EN(1), .ERRW(8)) u_dut_b (
    .RXClk(clk), .RXResetN(rst_n), .RXData(rx_data),
    .WordOut(word_b), .WordValid(valid_b), .WordReady(ready),
    .FrameErr(ferr_b), .ParityErr(perr_b), .Overrun(ovr_b), .ErrCount(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;  // 0: 32-bit no parity, 1: 24-bit with parity

  // Frame-level reference: holding slot contents and expected pulses.
  logic        m_valid;
  logic [31:0] m_word;
  int          m_cnt;
  logic        m_ferr, m_perr, m_ovr;

  localparam int EvNone = 0, EvGood = 1, EvFrame = 2, EvParity = 3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    logic        v, fe, pe, ov;
    logic [7:0]  c;
    if (sel == 0) begin
      w = word_a; v = valid_a; fe = ferr_a; pe = perr_a; ov = ovr_a; c = cnt_a;
    end else begin
      w = {8'h00, word_b}; v = valid_b; fe = ferr_b; pe = perr_b; ov = ovr_b; c = cnt_b;
    end
    check_eq("WordValid", {31'd0, v}, {31'd0, m_valid});
    if (m_valid) check_eq("WordOut", w, m_word);
    check_eq("FrameErr", {31'd0, fe}, {31'd0, m_ferr});
    check_eq("ParityErr", {31'd0, pe}, {31'd0, m_perr});
    check_eq("Overrun", {31'd0, ov}, {31'd0, m_ovr});
    check_eq("ErrCount", {24'd0, c}, m_cnt);
  endtask

  task automatic bump_cnt();
    if (m_cnt < 255) m_cnt++;
  endtask

  // Drive one line bit, clock it in, advance the reference, then check.
  task automatic step(input logic b, input logic rdy, input int ev, input logic [31:0] word);
    rx_data = b;
    ready   = rdy;
    @(posedge clk);
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_ovr  = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    case (ev)
      EvGood: begin
        if (m_valid) begin
          m_ovr = 1'b1;
          bump_cnt();
        end else begin
          m_word  = word;
          m_valid = 1'b1;
        end
      end
      EvFrame:  begin m_ferr = 1'b1; bump_cnt(); end
      EvParity: begin m_perr = 1'b1; bump_cnt(); end
      default: ;
    endcase
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_data = 1'b0;
    ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_valid = 1'b0; m_word = '0; m_cnt = 0;
    m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    #1;
    check_eq("reset WordOut", (sel == 0) ? word_a : {8'h00, word_b}, 32'h0);
    check_outputs();
    rst_n = 1'b1;
  endtask

  function automatic logic pick_rdy(input int mode);
    return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode[0]);
  endfunction

  // rdy_mode: 0/1 fixed WordReady during the frame, 2 random per cycle.
  task automatic send_frame(input logic [31:0] data, input logic bad_par, input logic bad_stop,
                            input int rdy_mode, input logic rdy_stop);
    int          w;
    logic        pe;
    logic [31:0] d;
    int          ev;
    w  = (sel == 0) ? 32 : 24;
    pe = (sel != 0);
    d  = (sel == 0) ? data : (data & 32'h00ff_ffff);
    step(1'b1, pick_rdy(rdy_mode), EvNone, '0);
    for (int i = 0; i < w; i++) step(d[i], pick_rdy(rdy_mode), EvNone, '0);
    if (pe) step((^d) ^ bad_par, pick_rdy(rdy_mode), EvNone, '0);
    if (bad_stop)             ev = EvFrame;
    else if (pe && bad_par)   ev = EvParity;
    else                      ev = EvGood;
    step(bad_stop, rdy_stop, ev, d);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, EvNone, '0);
  endtask

  task automatic random_frames(input int n);
    for (int k = 0; k < n; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      send_frame($urandom, kind == 1, kind == 0, 2, logic'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, logic'($urandom_range(0, 1)),
                                                          EvNone, '0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 1'b0; ready = 1'b0;
    m_valid = 1'b0; m_word = '0; m_cnt = 0;
    m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;

    // 32-bit, no parity
    sel = 0;
    do_reset();
    idle(2, 1'b1);
    send_frame(32'hdeadbeef, 1'b0, 1'b0, 1, 1'b1);
    idle(3, 1'b1);
    // Bad stop bit, then a clean frame immediately after
    send_frame(32'h12345678, 1'b0, 1'b1, 1, 1'b1);
    send_frame(32'h00000001, 1'b0, 1'b0, 1, 1'b1);
    idle(2, 1'b1);
    // Overrun with consumer stalled
    send_frame(32'hAAAA5555, 1'b0, 1'b0, 0, 1'b0);
    send_frame(32'h5555AAAA, 1'b0, 1'b0, 0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // Handshake and commit on the same edge
    send_frame(32'h11112222, 1'b0, 1'b0, 0, 1'b0);
    send_frame(32'h33334444, 1'b0, 1'b0, 0, 1'b1);
    idle(2, 1'b1);
    // Reset mid-frame
    step(1'b1, 1'b1, EvNone, '0);
    for (int i = 0; i < 10; i++) step(logic'(i % 2), 1'b1, EvNone, '0);
    do_reset();
    send_frame(32'hcafef00d, 1'b0, 1'b0, 1, 1'b1);
    idle(1, 1'b1);
    random_frames(40);
    // Counter saturation
    do_reset();
    for (int i = 0; i < 261; i++) send_frame($urandom, 1'b0, 1'b1, 1, 1'b1);
    check_eq("ErrCount saturated", {24'd0, cnt_a}, 32'd255);

    // 24-bit with parity
    sel = 1;
    do_reset();
    idle(1, 1'b1);
    send_frame(32'h00c0ffee, 1'b0, 1'b0, 1, 1'b1);
    idle(2, 1'b1);
    send_frame(32'h00c0ffee, 1'b1, 1'b0, 1, 1'b1);
    idle(2, 1'b1);
    // Bad stop plus bad parity: framing error only
    send_frame(32'h00123456, 1'b1, 1'b1, 1, 1'b1);
    idle(1, 1'b1);
    random_frames(40);
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
